// File: rtl/gppcu_thread_fpseq.sv
// Execute-stage result sequencer for one GPPCU thread: merges single-cycle ALU
// results with a start/done FPU behind a stall, and registers writeback result/flags.
module gppcu_thread_fpseq #(
  parameter int DBW     = 32,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic           iACLK,
  input  logic           iARESETn,
  input  logic           iVALID,
  input  logic           iIS_FP,
  input  logic           iSET_S,
  input  logic [OPW-1:0] iFPOP,
  input  logic [DBW-1:0] iOPRA,
  input  logic [DBW-1:0] iOPRB,
  input  logic [DBW-1:0] iALU_Q,
  input  logic [3:0]     iALU_SREG,
  output logic           oBUSY,
  output logic           oFP_START,
  output logic [OPW-1:0] oFP_N,
  output logic [DBW-1:0] oFP_A,
  output logic [DBW-1:0] oFP_B,
  input  logic           iFP_DONE,
  input  logic [DBW-1:0] iFP_RESULT,
  output logic [DBW-1:0] oQ,
  output logic           oQ_VALID,
  output logic [3:0]     oSREG,
  output logic           oFP_ERR,
  input  logic           iCLR_ERR
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DBW-1:0] hold_q, hold_d;
  logic           sset_q, sset_d;
  logic           tout_q, tout_d;
  logic           start_q, start_d;
  logic [OPW-1:0] fpn_q, fpn_d;
  logic [DBW-1:0] fpa_q, fpa_d;
  logic [DBW-1:0] fpb_q, fpb_d;
  logic [DBW-1:0] q_q, q_d;
  logic           qv_q, qv_d;
  logic [3:0]     sreg_q, sreg_d;
  logic           err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    sset_d  = sset_q;
    tout_d  = tout_q;
    fpn_d   = fpn_q;
    fpa_d   = fpa_q;
    fpb_d   = fpb_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    sreg_d  = sreg_q;
    err_d   = err_q & ~iCLR_ERR;
    case (state_q)
      S_IDLE: begin
        if (iVALID && iIS_FP) begin
          fpa_d   = iOPRA;
          fpb_d   = iOPRB;
          fpn_d   = iFPOP;
          sset_d  = iSET_S;
          tout_d  = 1'b0;
          state_d = S_ISSUE;
        end else if (iVALID) begin
          q_d  = iALU_Q;
          qv_d = 1'b1;
          if (iSET_S) sreg_d = iALU_SREG;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (iFP_DONE) begin
          hold_d  = iFP_RESULT;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a done pulse on the last watchdog cycle still counts as a real result
        if (iFP_DONE) begin
          hold_d  = iFP_RESULT;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          hold_d  = '1;
          tout_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        q_d  = hold_q;
        qv_d = 1'b1;
        if (sset_q && !tout_q)
          sreg_d = {1'b0, sreg_q[2], hold_q[DBW-1], hold_q[DBW-2:0] == '0};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      sset_q  <= 1'b0;
      tout_q  <= 1'b0;
      start_q <= 1'b0;
      fpn_q   <= '0;
      fpa_q   <= '0;
      fpb_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      sreg_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sset_q  <= sset_d;
      tout_q  <= tout_d;
      start_q <= start_d;
      fpn_q   <= fpn_d;
      fpa_q   <= fpa_d;
      fpb_q   <= fpb_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      sreg_q  <= sreg_d;
      err_q   <= err_d;
    end
  end

  // stall must drop while reset is asserted even if the pipeline still presents an FP op
  assign oBUSY = iARESETn & (((state_q == S_IDLE) & iVALID & iIS_FP) |
                             (state_q == S_ISSUE) | (state_q == S_WAIT));

  assign oFP_START = start_q;
  assign oFP_N     = fpn_q;
  assign oFP_A     = fpa_q;
  assign oFP_B     = fpb_q;
  assign oQ        = q_q;
  assign oQ_VALID  = qv_q;
  assign oSREG     = sreg_q;
  assign oFP_ERR   = err_q;

endmodule

// File: tb/tb_gppcu_thread_fpseq.sv
// Directed bench for gppcu_thread_fpseq: scoreboard of expected writebacks plus
// stall/start/error checks around ALU ops, FPU latencies, timeout and reset.
module tb_gppcu_thread_fpseq;
  localparam int TO = 64;

  logic        iACLK, iARESETn;
  logic        iVALID, iIS_FP, iSET_S, iFP_DONE, iCLR_ERR;
  logic [2:0]  iFPOP;
  logic [31:0] iOPRA, iOPRB, iALU_Q, iFP_RESULT;
  logic [3:0]  iALU_SREG;
  logic        oBUSY, oFP_START, oQ_VALID, oFP_ERR;
  logic [2:0]  oFP_N;
  logic [31:0] oFP_A, oFP_B, oQ;
  logic [3:0]  oSREG;

  gppcu_thread_fpseq #(.DBW(32), .OPW(3), .TIMEOUT(TO)) dut (
    .iACLK(iACLK), .iARESETn(iARESETn), .iVALID(iVALID), .iIS_FP(iIS_FP),
    .iSET_S(iSET_S), .iFPOP(iFPOP), .iOPRA(iOPRA), .iOPRB(iOPRB),
    .iALU_Q(iALU_Q), .iALU_SREG(iALU_SREG), .oBUSY(oBUSY), .oFP_START(oFP_START),
    .oFP_N(oFP_N), .oFP_A(oFP_A), .oFP_B(oFP_B), .iFP_DONE(iFP_DONE),
    .iFP_RESULT(iFP_RESULT), .oQ(oQ), .oQ_VALID(oQ_VALID), .oSREG(oSREG),
    .oFP_ERR(oFP_ERR), .iCLR_ERR(iCLR_ERR)
  );

  typedef struct {
    logic [31:0] q;
    logic [3:0]  s;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] sreg_m = 4'b0;
  logic       err_m = 1'b0;

  initial begin
    iACLK = 1'b0;
    forever #5 iACLK = ~iACLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: every oQ_VALID pulse must match the oldest expected writeback
  always @(negedge iACLK) begin
    if (iARESETn && oQ_VALID) begin
      if (sb.size() == 0) begin
        chk("unexpected_qv", {63'b0, oQ_VALID}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_q", {32'b0, oQ}, {32'b0, e.q});
        chk("wb_sreg", {60'b0, oSREG}, {60'b0, e.s});
      end
    end
  end

  task automatic alu_op(input string tag, input logic [31:0] q, input logic [3:0] sr,
                        input logic sset);
    exp_t e;
    if (sset) sreg_m = sr;
    e.q = q; e.s = sreg_m;
    sb.push_back(e);
    iVALID = 1'b1; iIS_FP = 1'b0; iSET_S = sset; iALU_Q = q; iALU_SREG = sr;
    @(negedge iACLK);
    chk({tag, "_busy"}, {63'b0, oBUSY}, 64'd0);
    @(posedge iACLK); #1;
    iVALID = 1'b0;
    @(negedge iACLK);
    chk({tag, "_qv"}, {63'b0, oQ_VALID}, 64'd1);
    @(posedge iACLK); #1;
  endtask

  // lat < 0: FPU never answers; otherwise iFP_DONE lat cycles after the start pulse
  task automatic fp_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic sset, input int lat,
                       input logic [31:0] res);
    exp_t e;
    bit   tout, ended;
    int   s, busy, starts;
    tout = (lat < 0) || (lat > TO);
    e.q = tout ? 32'hFFFF_FFFF : res;
    if (sset && !tout) sreg_m = {1'b0, sreg_m[2], res[31], res[30:0] == 31'd0};
    e.s = sreg_m;
    if (tout) err_m = 1'b1;
    sb.push_back(e);
    iVALID = 1'b1; iIS_FP = 1'b1; iSET_S = sset; iFPOP = op;
    iOPRA = a; iOPRB = b; iFP_RESULT = res; iALU_Q = 32'hDEAD_BEEF;
    s = -1; busy = 0; starts = 0; ended = 0;
    for (int c = 0; c < 400; c++) begin
      if (oFP_START) begin
        starts++;
        s = c;
        chk({tag, "_fpa"}, {32'b0, oFP_A}, {32'b0, a});
        chk({tag, "_fpb"}, {32'b0, oFP_B}, {32'b0, b});
        chk({tag, "_fpn"}, {61'b0, oFP_N}, {61'b0, op});
      end
      iFP_DONE = (lat >= 0) && (s >= 0) && (c == s + lat);
      @(negedge iACLK);
      if (oBUSY) busy++;
      else begin
        ended = 1;
        break;
      end
      @(posedge iACLK); #1;
    end
    chk({tag, "_ended"}, {63'b0, ended}, 64'd1);
    @(posedge iACLK); #1;
    iVALID = 1'b0; iIS_FP = 1'b0; iFP_DONE = 1'b0;
    @(negedge iACLK);
    chk({tag, "_qv"}, {63'b0, oQ_VALID}, 64'd1);
    chk({tag, "_busycyc"}, 64'(busy), tout ? 64'(TO + 2) : 64'(lat + 2));
    chk({tag, "_starts"}, 64'(starts), 64'd1);
    chk({tag, "_err"}, {63'b0, oFP_ERR}, {63'b0, err_m});
    @(posedge iACLK); #1;
  endtask

  initial begin
    iARESETn = 1'b0; iVALID = 1'b0; iIS_FP = 1'b0; iSET_S = 1'b0; iFP_DONE = 1'b0;
    iCLR_ERR = 1'b0; iFPOP = '0; iOPRA = '0; iOPRB = '0; iALU_Q = '0;
    iFP_RESULT = '0; iALU_SREG = '0;
    #12;
    chk("rst_busy", {63'b0, oBUSY}, 64'd0);
    chk("rst_start", {63'b0, oFP_START}, 64'd0);
    chk("rst_qv", {63'b0, oQ_VALID}, 64'd0);
    chk("rst_err", {63'b0, oFP_ERR}, 64'd0);
    chk("rst_q", {32'b0, oQ}, 64'd0);
    chk("rst_sreg", {60'b0, oSREG}, 64'd0);
    chk("rst_fpab", {oFP_A, oFP_B}, 64'd0);
    chk("rst_fpn", {61'b0, oFP_N}, 64'd0);
    @(posedge iACLK); #1;
    iARESETn = 1'b1;
    @(posedge iACLK); #1;

    alu_op("alu5", 32'h0000_0005, 4'b0000, 1'b1);
    alu_op("alu_c", 32'h0000_1234, 4'b0100, 1'b1);
    alu_op("alu_nos", 32'hCAFE_0001, 4'b1111, 1'b0);

    fp_op("fp_l5", 32'h3F80_0000, 32'h4000_0000, 3'd2, 1'b1, 5, 32'h8000_0000);
    chk("fp_l5_sreg", {60'b0, oSREG}, 64'h7);
    fp_op("fp_l0", 32'h1111_1111, 32'h2222_2222, 3'd5, 1'b1, 0, 32'h0000_0000);
    fp_op("fp_nos", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd7, 1'b0, 3, 32'h0000_0007);

    fp_op("fp_tout", 32'h0BAD_0001, 32'h0BAD_0002, 3'd1, 1'b1, -1, 32'h1234_5678);
    @(negedge iACLK);
    chk("err_sticky", {63'b0, oFP_ERR}, 64'd1);
    @(posedge iACLK); #1;
    iCLR_ERR = 1'b1; err_m = 1'b0;
    @(posedge iACLK); #1;
    iCLR_ERR = 1'b0;
    @(negedge iACLK);
    chk("err_clr", {63'b0, oFP_ERR}, 64'd0);
    @(posedge iACLK); #1;

    fp_op("fp_edge", 32'h0000_00AA, 32'h0000_00BB, 3'd3, 1'b1, TO, 32'h0000_0001);

    // reset while the op sits in WAIT, then a stray done pulse
    iVALID = 1'b1; iIS_FP = 1'b1; iSET_S = 1'b1; iFPOP = 3'd6;
    iOPRA = 32'hFFFF_0000; iOPRB = 32'h0000_FFFF; iFP_RESULT = 32'h4444_4444;
    repeat (5) begin @(posedge iACLK); #1; end
    chk("pre_rst_busy", {63'b0, oBUSY}, 64'd1);
    #2 iARESETn = 1'b0;
    #1;
    chk("mid_rst_busy", {63'b0, oBUSY}, 64'd0);
    chk("mid_rst_q", {28'b0, oSREG, oQ}, 64'd0);
    chk("mid_rst_fpab", {oFP_A, oFP_B}, 64'd0);
    iVALID = 1'b0; iIS_FP = 1'b0; sreg_m = 4'b0;
    @(posedge iACLK); #1;
    iARESETn = 1'b1;
    iFP_DONE = 1'b1;
    @(negedge iACLK);
    chk("stray_busy", {63'b0, oBUSY}, 64'd0);
    @(posedge iACLK); #1;
    iFP_DONE = 1'b0;
    repeat (3) begin
      @(negedge iACLK);
      chk("post_rst_idle", {60'b0, oBUSY, oFP_START, oQ_VALID, oFP_ERR}, 64'd0);
      @(posedge iACLK); #1;
    end
    chk("post_rst_q", {28'b0, oSREG, oQ}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
